// File: rtl/fu_branch_predictor_bimodal.sv
// Bimodal branch predictor: direct-mapped tagged BTB plus saturating-counter PHT (gshare index with BP_GSHARE_EN).
// Latency: lookup is combinational (0 cycles); an update is visible on the cycle after its strobe.
// Backpressure: none; one update is accepted every cycle and a lookup never stalls.
module fu_branch_predictor_bimodal #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc,
    output logic        predicted_outcome,
    output logic [31:0] predicted_target,
    output logic        btb_hit,
    input  logic        update_btb,
    input  logic [31:0] update_pc,
    input  logic        branch_outcome,
    input  logic [31:0] branch_target
);

    typedef logic [31:0] word_t;

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_MAX >> 1;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    word_t             target_q [ENTRIES];
    logic [CTR_BITS-1:0] pht_q  [ENTRIES];

    logic [IDX_W-1:0]  lkp_idx;
    logic [TAG_W-1:0]  lkp_tag;
    logic [IDX_W-1:0]  lkp_pidx;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic [IDX_W-1:0]  upd_pidx;
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_nxt;

    // Word alignment makes the two PC LSBs meaningless to the predictor.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc[1:0], update_pc[1:0]};

    assign lkp_idx = pc[IDX_W+1:2];
    assign lkp_tag = pc[31:IDX_W+2];
    assign upd_idx = update_pc[IDX_W+1:2];
    assign upd_tag = update_pc[31:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    assign lkp_pidx = lkp_idx ^ ghr_q;
    assign upd_pidx = upd_idx ^ ghr_q;

    generate
        if (IDX_W == 1) begin : g_ghr_one
            always_ff @(posedge CLK) begin
                if (RST) begin
                    ghr_q <= '0;
                end else if (update_btb) begin
                    ghr_q <= branch_outcome;
                end
            end
        end else begin : g_ghr_shift
            always_ff @(posedge CLK) begin
                if (RST) begin
                    ghr_q <= '0;
                end else if (update_btb) begin
                    ghr_q <= {ghr_q[IDX_W-2:0], branch_outcome};
                end
            end
        end
    endgenerate
`else
    assign lkp_pidx = lkp_idx;
    assign upd_pidx = upd_idx;
`endif

    // Lookup always sees the pre-update arrays; there is deliberately no bypass.
    always_comb begin
        btb_hit           = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
        predicted_outcome = btb_hit && pht_q[lkp_pidx][CTR_BITS-1];
        predicted_target  = predicted_outcome ? target_q[lkp_idx] : (pc + 32'd4);
    end

    always_comb begin
        ctr_cur = pht_q[upd_pidx];
        ctr_nxt = ctr_cur;
        if (branch_outcome) begin
            if (ctr_cur != CTR_MAX) begin
                ctr_nxt = ctr_cur + CTR_ONE;
            end
        end else if (ctr_cur != '0) begin
            ctr_nxt = ctr_cur - CTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                pht_q[i]   <= CTR_RST;
            end
        end else if (update_btb) begin
            pht_q[upd_pidx] <= ctr_nxt;
            if (branch_outcome) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // A taken branch both refreshes a hit and allocates over any alias; not-taken leaves the BTB alone.
    always_ff @(posedge CLK) begin
        if (!RST && update_btb && branch_outcome) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= branch_target;
        end
    end

endmodule

// File: tb/tb_fu_branch_predictor_bimodal.sv
// Scoreboard bench for fu_branch_predictor_bimodal (ENTRIES=16, CTR_BITS=2).
module tb_fu_branch_predictor_bimodal;

    logic        CLK;
    logic        RST;
    logic [31:0] pc;
    logic        predicted_outcome;
    logic [31:0] predicted_target;
    logic        btb_hit;
    logic        update_btb;
    logic [31:0] update_pc;
    logic        branch_outcome;
    logic [31:0] branch_target;

    typedef struct packed {
        logic        hit;
        logic        outcome;
        logic [31:0] target;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fu_branch_predictor_bimodal #(.ENTRIES(16), .CTR_BITS(2)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .pc                (pc),
        .predicted_outcome (predicted_outcome),
        .predicted_target  (predicted_target),
        .btb_hit           (btb_hit),
        .update_btb        (update_btb),
        .update_pc         (update_pc),
        .branch_outcome    (branch_outcome),
        .branch_target     (branch_target)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle: optional update plus a lookup, expected lookup pushed to the scoreboard
    // and popped once the combinational outputs have settled (before the next rising edge).
    task automatic step(input string tag, input logic rst, input logic upd, input logic [31:0] upc,
                        input logic outc, input logic [31:0] tgt, input logic [31:0] lpc,
                        input logic eh, input logic eo, input logic [31:0] et);
        exp_t e;
        @(negedge CLK);
        RST            = rst;
        update_btb     = upd;
        update_pc      = upc;
        branch_outcome = outc;
        branch_target  = tgt;
        pc             = lpc;
        sb_q.push_back('{hit: eh, outcome: eo, target: et});
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_hit"}, {31'd0, btb_hit}, {31'd0, e.hit});
            check_val({tag, "_out"}, {31'd0, predicted_outcome}, {31'd0, e.outcome});
            check_val({tag, "_tgt"}, predicted_target, e.target);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST        = 1'b1;
        update_btb = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST            = 1'b1;
        pc             = 32'h0;
        update_btb     = 1'b0;
        update_pc      = 32'h0;
        branch_outcome = 1'b0;
        branch_target  = 32'h0;
        do_reset();

`ifdef BP_GSHARE_EN
        step("gs_u1",   0, 1, 32'h10, 1, 32'h08, 32'h10, 0, 0, 32'h14);
        step("gs_u2",   0, 1, 32'h10, 1, 32'h08, 32'h10, 1, 0, 32'h14);
        step("gs_look", 0, 0, 32'h0,  0, 32'h0,  32'h10, 1, 0, 32'h14);
        step("gs_miss", 0, 0, 32'h0,  0, 32'h0,  32'h14, 0, 0, 32'h18);
`else
        // Reset state, including wrap of pc+4 at the top of the address space.
        step("rst_10",  0, 0, 32'h0,  0, 32'h0,  32'h10,       0, 0, 32'h14);
        step("rst_0",   0, 0, 32'h0,  0, 32'h0,  32'h0,        0, 0, 32'h4);
        step("rst_top", 0, 0, 32'h0,  0, 32'h0,  32'hFFFFFFFC, 0, 0, 32'h0);

        // Allocate 0x10 taken; same-cycle lookup sees the old state.
        step("alloc",   0, 1, 32'h10, 1, 32'h08, 32'h10, 0, 0, 32'h14);
        step("hit_t",   0, 0, 32'h0,  0, 32'h0,  32'h10, 1, 1, 32'h08);

        // Counter walk 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10.
        step("nt1",     0, 1, 32'h10, 0, 32'h0,  32'h10, 1, 1, 32'h08);
        step("nt2",     0, 1, 32'h10, 0, 32'h0,  32'h10, 1, 0, 32'h14);
        step("t1",      0, 1, 32'h10, 1, 32'h08, 32'h10, 1, 0, 32'h14);
        step("t2",      0, 1, 32'h10, 1, 32'h08, 32'h10, 1, 0, 32'h14);
        step("t3",      0, 1, 32'h10, 1, 32'h08, 32'h10, 1, 1, 32'h08);
        step("t4",      0, 1, 32'h10, 1, 32'h08, 32'h10, 1, 1, 32'h08);
        step("nt_sat",  0, 1, 32'h10, 0, 32'h0,  32'h10, 1, 1, 32'h08);
        step("sat_chk", 0, 0, 32'h0,  0, 32'h0,  32'h10, 1, 1, 32'h08);

        // Hit + taken overwrites the target.
        step("retgt",   0, 1, 32'h10, 1, 32'h200, 32'h10, 1, 1, 32'h08);
        step("retgt_c", 0, 0, 32'h0,  0, 32'h0,   32'h10, 1, 1, 32'h200);

        // Alias 0x50 (idx 4, tag 1) evicts 0x10.
        step("alias_m", 0, 0, 32'h0,  0, 32'h0,   32'h50, 0, 0, 32'h54);
        step("alias_u", 0, 1, 32'h50, 1, 32'h100, 32'h50, 0, 0, 32'h54);
        step("evicted", 0, 0, 32'h0,  0, 32'h0,   32'h10, 0, 0, 32'h14);
        step("alias_h", 0, 0, 32'h0,  0, 32'h0,   32'h50, 1, 1, 32'h100);

        // Miss + not-taken: BTB untouched but shared counter still decrements (11 -> 10 -> 01).
        step("mnt1",    0, 1, 32'h90, 0, 32'h0,   32'h50, 1, 1, 32'h100);
        step("mnt2",    0, 1, 32'h90, 0, 32'h0,   32'h50, 1, 1, 32'h100);
        step("mnt_chk", 0, 0, 32'h0,  0, 32'h0,   32'h50, 1, 0, 32'h54);
        step("mnt_90",  0, 0, 32'h0,  0, 32'h0,   32'h90, 0, 0, 32'h94);

        // Same-cycle update/lookup returns pre-update state.
        step("same_cy", 0, 1, 32'h30, 1, 32'h40,  32'h30, 0, 0, 32'h34);
        step("same_nx", 0, 0, 32'h0,  0, 32'h0,   32'h30, 1, 1, 32'h40);

        // Last index and an all-ones tag.
        step("idx15_u", 0, 1, 32'hFFFFFFFC, 1, 32'hABC, 32'hFFFFFFFC, 0, 0, 32'h0);
        step("idx15_h", 0, 0, 32'h0,  0, 32'h0,   32'hFFFFFFFC, 1, 1, 32'hABC);
        step("idx15_a", 0, 0, 32'h0,  0, 32'h0,   32'h3C, 0, 0, 32'h40);

        // Reset wins over a concurrent update.
        step("rst_upd", 1, 1, 32'h70, 1, 32'h80,  32'h30, 1, 1, 32'h40);
        step("post_30", 0, 0, 32'h0,  0, 32'h0,   32'h30, 0, 0, 32'h34);
        step("post_70", 0, 0, 32'h0,  0, 32'h0,   32'h70, 0, 0, 32'h74);
        step("post_50", 0, 0, 32'h0,  0, 32'h0,   32'h50, 0, 0, 32'h54);
        step("post_ff", 0, 0, 32'h0,  0, 32'h0,   32'hFFFFFFFC, 0, 0, 32'h0);

        // Counter back at weakly-not-taken: one taken update flips the prediction.
        step("wnt_u",   0, 1, 32'h30, 1, 32'h40,  32'h30, 0, 0, 32'h34);
        step("wnt_h",   0, 0, 32'h0,  0, 32'h0,   32'h30, 1, 1, 32'h40);
`endif

        if (sb_q.size() != 0) begin
            check_val("sb_drain", sb_q.size(), 32'd0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
